// File: rtl/max_pooling_layer_param.sv
// max_pooling_layer_param
// 2x2 / stride-2 pooling over CHANNELS parallel raster-order pixel streams.
// MODE 0 takes the window maximum (signed or unsigned compare); MODE 1 takes
// the rounded window mean. The top row of each window pair is reduced
// horizontally and parked in a shared half-row line buffer. The bottom row
// completes the window, one column pair at a time. An odd last column or an
// odd last row is consumed and ignored.
module max_pooling_layer_param #(
    parameter int CHANNELS = 16,
    parameter int DATA_W   = 1,
    parameter int WIDTH    = 11,
    parameter int HEIGHT   = 11,
    parameter int SIGNED   = 0,
    parameter int MODE     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [CHANNELS*DATA_W-1:0] pixel_in,
    output logic [CHANNELS*DATA_W-1:0] maxpool_out,
    output logic                       valid_out,
    output logic                       frame_done
);

    // Pooled output grid and counter/buffer geometry.
    localparam int W2    = WIDTH / 2;
    localparam int H2    = HEIGHT / 2;
    localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int IDX_W = (W2 > 1) ? $clog2(W2) : 1;

    // Per-channel widths: pixel, horizontal pair (one growth bit), full window sum.
    localparam int PW    = DATA_W + 1;
    localparam int SW    = DATA_W + 2;
    localparam int BUS_W = CHANNELS * DATA_W;
    localparam int LB_W  = CHANNELS * PW;

    // Raster position of the pixel currently presented on pixel_in.
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Left pixel of the current horizontal pair, all channels.
    logic [BUS_W-1:0] r_hold;

    // One reduced top-row pair per output column, all channels.
    logic [LB_W-1:0]  r_lbuf [W2];

    // Registered outputs.
    logic [BUS_W-1:0] r_out;
    logic             r_valid_out;
    logic             r_frame_done;

    // Decoded position and enables for the current input pixel.
    logic             w_col_last;
    logic             w_row_last;
    logic             w_hold_en;
    logic             w_lb_wr_en;
    logic             w_out_en;
    logic [IDX_W-1:0] w_idx;

    // Line-buffer read data, new pair to store, finished window results.
    logic [LB_W-1:0]  w_lb_rd;
    logic [LB_W-1:0]  w_pair;
    logic [BUS_W-1:0] w_result;

    // Ordering compare. Signed mode flips the sign bit so that a plain
    // unsigned compare orders two's-complement values correctly.
    function automatic logic f_gt(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] a_k;
        logic [DATA_W-1:0] b_k;
        a_k = a;
        b_k = b;
        if (SIGNED != 0) begin
            a_k[DATA_W-1] = ~a[DATA_W-1];
            b_k[DATA_W-1] = ~b[DATA_W-1];
        end
        return a_k > b_k;
    endfunction

    // Larger of two pixels under the configured signedness.
    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return f_gt(a, b) ? a : b;
    endfunction

    // Widen a pixel by one bit (sign- or zero-extend).
    function automatic logic [PW-1:0] f_ext1(input logic [DATA_W-1:0] a);
        return {((SIGNED != 0) && a[DATA_W-1]), a};
    endfunction

    // Widen a pair value by one more bit (sign- or zero-extend).
    function automatic logic [SW-1:0] f_ext2(input logic [PW-1:0] a);
        return {((SIGNED != 0) && a[PW-1]), a};
    endfunction

    // Horizontal reduction of the top row: max, or a growth-safe sum.
    function automatic logic [PW-1:0] f_pair(input logic [DATA_W-1:0] h,
                                             input logic [DATA_W-1:0] p);
        if (MODE == 0) begin
            return {1'b0, f_max(h, p)};
        end
        return f_ext1(h) + f_ext1(p);
    endfunction

    // Finish a window from the buffered top pair and the bottom-row pixels.
    // The mean keeps bits [SW-1:2] of (sum + 2). Those bits equal the
    // arithmetic shift truncated to DATA_W, for either signedness.
    function automatic logic [DATA_W-1:0] f_comb(input logic [PW-1:0]     lb,
                                                 input logic [DATA_W-1:0] h,
                                                 input logic [DATA_W-1:0] p);
        logic [SW-1:0] sum;
        if (MODE == 0) begin
            return f_max(lb[DATA_W-1:0], f_max(h, p));
        end
        sum = f_ext2(lb) + f_ext2(f_ext1(h)) + f_ext2(f_ext1(p)) + SW'(2);
        return sum[SW-1:2];
    endfunction

    // Position decode. An odd trailing column or row never enables storage
    // or output; its pixels are simply consumed.
    assign w_col_last = (r_col == COL_W'(WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(HEIGHT - 1));
    assign w_hold_en  = valid_in && !r_col[0] && (int'(r_col) < 2 * W2);
    assign w_lb_wr_en = valid_in && r_col[0] && !r_row[0] && (int'(r_row) < 2 * H2);
    assign w_out_en   = valid_in && r_col[0] && r_row[0];
    assign w_idx      = IDX_W'(r_col >> 1);
    assign w_lb_rd    = r_lbuf[w_idx];

    // Per-channel datapath: pair for the line buffer and finished window result.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_pair   = '0;
        w_result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_pair[c*PW +: PW] = f_pair(r_hold[c*DATA_W +: DATA_W],
                                        pixel_in[c*DATA_W +: DATA_W]);
            w_result[c*DATA_W +: DATA_W] = f_comb(w_lb_rd[c*PW +: PW],
                                                  r_hold[c*DATA_W +: DATA_W],
                                                  pixel_in[c*DATA_W +: DATA_W]);
        end
    end

    // Raster column/row counters. They advance only on accepted pixels.
    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Data storage: horizontal hold register and half-row line buffer.
    // NOTE: no reset here; every entry is written before it is read in a frame,
    //       and leaving reset off keeps the buffer mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (w_hold_en) begin
            r_hold <= pixel_in;
        end
        if (w_lb_wr_en) begin
            r_lbuf[w_idx] <= w_pair;
        end
    end

    // Registered result, valid pulse and end-of-frame pulse.
    // The result register holds its value between valid pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= w_out_en;
            r_frame_done <= valid_in && w_col_last && w_row_last;
            if (w_out_en) begin
                r_out <= w_result;
            end
        end
    end

    assign maxpool_out = r_out;
    assign valid_out   = r_valid_out;
    assign frame_done  = r_frame_done;

endmodule
